// File: rtl/cla_pipe_addsub.sv
// Pipelined two-level carry-lookahead adder/subtractor with valid/ready flow control.
// Subtract mode computes A + ~B + 1; ovf is carry-into-MSB XOR carry-out.
// STAGES=1 registers only the result; STAGES=2 adds a register after the
// group-carry lookahead so the in-group carry/sum logic sits in the second cycle.
module cla_pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NG = WIDTH / GROUP;

    if ((STAGES != 1) && (STAGES != 2)) begin : g_bad_stages
        $error("cla_pipe_addsub: STAGES must be 1 or 2");
    end
    if ((WIDTH % GROUP) != 0) begin : g_bad_group
        $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
    end

    // ---------------- front end: effective operands and group carries ----------
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_fg;
    logic [WIDTH-1:0] w_fp;
    logic             w_c0;
    logic [NG-1:0]    w_gg;
    logic [NG-1:0]    w_gp;
    logic [NG:0]      w_cg;

    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? 1'b1 : cin;
    assign w_fg    = a & w_b_eff;
    assign w_fp    = a | w_b_eff;

    // Group generate/propagate as fully expanded sum-of-products per group
    always_comb begin
        logic w_t;
        w_gg = {NG{1'b0}};
        w_gp = {NG{1'b0}};
        w_t  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            w_gp[j] = &w_fp[j*GROUP +: GROUP];
            for (int m = 0; m < GROUP; m++) begin
                w_t = w_fg[j*GROUP + m];
                for (int q = m + 1; q < GROUP; q++) begin
                    w_t = w_t & w_fp[j*GROUP + q];
                end
                w_gg[j] = w_gg[j] | w_t;
            end
        end
    end

    // Second-level lookahead: every group carry-in comes straight from c0 and the
    // group G/P terms, never from the previous group's carry (index NG is cout)
    always_comb begin
        logic w_t;
        w_cg = {(NG+1){1'b0}};
        w_t  = 1'b0;
        for (int j = 0; j <= NG; j++) begin
            w_t = w_c0;
            for (int q = 0; q < j; q++) begin
                w_t = w_t & w_gp[q];
            end
            w_cg[j] = w_t;
            for (int m = 0; m < j; m++) begin
                w_t = w_gg[m];
                for (int q = m + 1; q < j; q++) begin
                    w_t = w_t & w_gp[q];
                end
                w_cg[j] = w_cg[j] | w_t;
            end
        end
    end

    // ---------------- back end: in-group carries and sum -----------------------
    logic [WIDTH-1:0] w_x_a;
    logic [WIDTH-1:0] w_x_b;
    logic [NG:0]      w_x_cg;
    logic [WIDTH-1:0] w_xg;
    logic [WIDTH-1:0] w_xp;
    logic [WIDTH-1:0] w_bc;
    logic [WIDTH-1:0] w_sum;

    assign w_xg = w_x_a & w_x_b;
    assign w_xp = w_x_a | w_x_b;

    // In-group lookahead: each bit carry expanded from its own group carry-in
    always_comb begin
        logic w_t;
        logic w_c;
        w_bc = {WIDTH{1'b0}};
        w_t  = 1'b0;
        w_c  = 1'b0;
        for (int j = 0; j < NG; j++) begin
            for (int k = 0; k < GROUP; k++) begin
                w_c = w_x_cg[j];
                for (int q = 0; q < k; q++) begin
                    w_c = w_c & w_xp[j*GROUP + q];
                end
                for (int m = 0; m < k; m++) begin
                    w_t = w_xg[j*GROUP + m];
                    for (int q = m + 1; q < k; q++) begin
                        w_t = w_t & w_xp[j*GROUP + q];
                    end
                    w_c = w_c | w_t;
                end
                w_bc[j*GROUP + k] = w_c;
            end
        end
    end

    assign w_sum = w_x_a ^ w_x_b ^ w_bc;

    // ---------------- flow control and pipeline registers ---------------------
    logic             r_rdy_en;
    logic             r_out_v;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;
    logic             w_out_adv;
    logic             w_acc;
    logic             w_ld_v;

    assign w_out_adv = ~r_out_v | out_ready;
    assign w_acc     = in_valid & in_ready;

    // Keep in_ready low through reset and release it on the first clock after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
        end
    end

    if (STAGES == 2) begin : g_two
        logic             r_s1_v;
        logic [WIDTH-1:0] r_s1_a;
        logic [WIDTH-1:0] r_s1_b;
        logic [NG:0]      r_s1_cg;
        logic             w_s1_adv;

        assign w_s1_adv = ~r_s1_v | w_out_adv;
        assign in_ready = r_rdy_en & w_s1_adv;

        // Stage-1 register: operands and group carries of the accepted beat
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_v  <= 1'b0;
                r_s1_a  <= {WIDTH{1'b0}};
                r_s1_b  <= {WIDTH{1'b0}};
                r_s1_cg <= {(NG+1){1'b0}};
            end else if (w_s1_adv) begin
                r_s1_v <= w_acc;
                if (w_acc) begin
                    r_s1_a  <= a;
                    r_s1_b  <= w_b_eff;
                    r_s1_cg <= w_cg;
                end
            end
        end

        assign w_x_a  = r_s1_a;
        assign w_x_b  = r_s1_b;
        assign w_x_cg = r_s1_cg;
        assign w_ld_v = r_s1_v;
    end else begin : g_one
        assign in_ready = r_rdy_en & w_out_adv;
        assign w_x_a    = a;
        assign w_x_b    = w_b_eff;
        assign w_x_cg   = w_cg;
        assign w_ld_v   = w_acc;
    end

    // Output register: result is held while the consumer stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_v <= 1'b0;
            r_sum   <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_out_adv) begin
            r_out_v <= w_ld_v;
            if (w_ld_v) begin
                r_sum  <= w_sum;
                r_cout <= w_x_cg[NG];
                r_ovf  <= w_bc[WIDTH-1] ^ w_x_cg[NG];
            end
        end
    end

    assign out_valid = r_out_v;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Bench for cla_pipe_addsub: directed literal vectors, backpressure, streaming on
// three configurations, and reset mid-flight, all scored against an arithmetic model.
module tb_cla_pipe_addsub;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    // 16-bit, GROUP=4, STAGES=2
    logic [15:0] a0, b0, sum0;
    logic        cin0, sub0, iv0, or0, ir0, ov0, cout0, ovf0;
    // 32-bit shared stimulus for GROUP=4/STAGES=1 and GROUP=8/STAGES=2
    logic [31:0] a1, b1, sum1, sum2;
    logic        cin1, sub1, iv1, or1, ir1, ov1, cout1, ovf1, ir2, ov2, cout2, ovf2;

    int n_vec = 0;
    int n_err = 0;

    logic [33:0] q0[$];
    logic [33:0] q1[$];
    logic [33:0] q2[$];
    int acc0 = 0, acc1 = 0, acc2 = 0, pop0 = 0, pop1 = 0, pop2 = 0;
    logic        st0 = 1'b0;
    logic [33:0] held0 = 34'h0;

    always #5 clk = ~clk;

    cla_pipe_addsub #(.WIDTH(16), .GROUP(4), .STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a0), .b(b0),
        .cin(cin0), .sub(sub0), .out_valid(ov0), .out_ready(or0), .sum(sum0),
        .cout(cout0), .ovf(ovf0));

    cla_pipe_addsub #(.WIDTH(32), .GROUP(4), .STAGES(1)) dut_w4s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov1), .out_ready(or1), .sum(sum1),
        .cout(cout1), .ovf(ovf1));

    cla_pipe_addsub #(.WIDTH(32), .GROUP(8), .STAGES(2)) dut_w8s2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir2), .a(a1), .b(b1),
        .cin(cin1), .sub(sub1), .out_valid(ov2), .out_ready(or1), .sum(sum2),
        .cout(cout2), .ovf(ovf2));

    // Reference: plain modular arithmetic on n bits; returns {cout, ovf, sum[31:0]}
    function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic ci, input logic s, input int n);
        logic [31:0] mask, xs, ye, r;
        logic [32:0] full;
        logic        co, v;
        mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
        xs   = x & mask;
        ye   = (s ? ~y : y) & mask;
        full = {1'b0, xs} + {1'b0, ye} + {32'h0, (s ? 1'b1 : ci)};
        r    = full[31:0] & mask;
        co   = full[n];
        v    = (xs[n-1] == ye[n-1]) && (r[n-1] != xs[n-1]);
        return {co, v, r};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic spur(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: got out_valid=1 expected no result outstanding", nm);
    endtask

    // Scoreboard for the 16-bit instance: push on accept, pop on delivery, check holds
    always @(negedge clk) begin
        if (!rst_n) begin
            q0.delete();
            st0 = 1'b0;
        end else begin
            if (st0 && ov0) chk("hold0", {30'h0, cout0, ovf0, sum0}, {30'h0, held0[33:32], held0[15:0]});
            if (ov0 && or0) begin
                pop0++;
                if (q0.size() == 0) spur("out0");
                else chk("out0", {30'h0, cout0, ovf0, 16'h0000, sum0}, {30'h0, q0.pop_front()});
            end
            st0   = ov0 && !or0;
            held0 = {cout0, ovf0, 16'h0000, sum0};
            if (iv0 && ir0) begin
                q0.push_back(model({16'h0000, a0}, {16'h0000, b0}, cin0, sub0, 16));
                acc0++;
            end
        end
    end

    // Scoreboard for the 32-bit GROUP=4 STAGES=1 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            q1.delete();
        end else begin
            if (ov1 && or1) begin
                pop1++;
                if (q1.size() == 0) spur("out_w4s1");
                else chk("out_w4s1", {30'h0, cout1, ovf1, sum1}, {30'h0, q1.pop_front()});
            end
            if (iv1 && ir1) begin
                q1.push_back(model(a1, b1, cin1, sub1, 32));
                acc1++;
            end
        end
    end

    // Scoreboard for the 32-bit GROUP=8 STAGES=2 instance
    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
        end else begin
            if (ov2 && or1) begin
                pop2++;
                if (q2.size() == 0) spur("out_w8s2");
                else chk("out_w8s2", {30'h0, cout2, ovf2, sum2}, {30'h0, q2.pop_front()});
            end
            if (iv1 && ir2) begin
                q2.push_back(model(a1, b1, cin1, sub1, 32));
                acc2++;
            end
        end
    end

    // One directed beat on the 16-bit instance with hand-computed results
    task automatic send0(input string nm, input logic [15:0] xa, input logic [15:0] xb,
                         input logic ci, input logic s, input logic [15:0] es,
                         input logic ec, input logic ev);
        int k;
        int lat;
        @(posedge clk);
        #1;
        a0 = xa; b0 = xb; cin0 = ci; sub0 = s; iv0 = 1'b1;
        k = 0;
        @(negedge clk);
        while (!ir0 && k < 10) begin
            k++;
            @(negedge clk);
        end
        chk({nm, "_accept_timeout"}, 64'(k < 10), 64'd1);
        @(posedge clk);
        #1;
        iv0 = 1'b0;
        lat = 0;
        while (lat < 10) begin
            @(negedge clk);
            lat++;
            if (ov0) break;
        end
        chk({nm, "_latency"}, 64'(lat), 64'd2);
        chk({nm, "_sum"}, {48'h0, sum0}, {48'h0, es});
        chk({nm, "_cout"}, {63'h0, cout0}, {63'h0, ec});
        chk({nm, "_ovf"}, {63'h0, ovf0}, {63'h0, ev});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] bpa [4];
        logic [15:0] bpb [4];
        logic [15:0] hs;
        int idx, accepts, c, p0, p1, p2, c0s, c1s, c2s;

        bpa = '{16'h0001, 16'h0010, 16'h0100, 16'h1000};
        bpb = '{16'h0002, 16'h0020, 16'h0200, 16'h2000};
        a0 = 16'h0; b0 = 16'h0; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b0; or0 = 1'b1;
        a1 = 32'h0; b1 = 32'h0; cin1 = 1'b0; sub1 = 1'b0; iv1 = 1'b0; or1 = 1'b1;

        // Reset state
        #12;
        chk("reset_state", {43'h0, ir0, ov0, cout0, ovf0, sum0}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ir_before_first_clk", {63'h0, ir0}, 64'd0);
        @(posedge clk);
        #1;
        chk("ir_after_release", {63'h0, ir0}, 64'd1);

        // Directed arithmetic
        send0("add_ffff_1",    16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        send0("add_7fff_1",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        send0("add_cin",       16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
        send0("sub_5_7",       16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        send0("sub_8000_1",    16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        send0("sub_7_5",       16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Backpressure: four beats offered with the consumer stalled
        @(posedge clk);
        #1;
        or0 = 1'b0;
        p0 = pop0;
        idx = 0; accepts = 0; c = 0;
        while (c < 6 && idx < 4) begin
            a0 = bpa[idx]; b0 = bpb[idx]; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
            @(negedge clk);
            if (ir0) begin idx++; accepts++; end
            @(posedge clk);
            #1;
            c++;
        end
        chk("bp_accepts", 64'(accepts), 64'd2);
        chk("bp_in_ready_low", {63'h0, ir0}, 64'd0);
        hs = sum0;
        repeat (3) @(posedge clk);
        #1;
        chk("bp_sum_stable", {48'h0, sum0}, {48'h0, hs});
        chk("bp_out_valid", {63'h0, ov0}, 64'd1);
        or0 = 1'b1;
        c = 0;
        while (c < 20 && idx < 4) begin
            a0 = bpa[idx]; b0 = bpb[idx]; iv0 = 1'b1;
            @(negedge clk);
            if (ir0) idx++;
            @(posedge clk);
            #1;
            c++;
        end
        iv0 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_delivered", 64'(pop0 - p0), 64'd4);
        chk("bp_queue_empty", 64'(q0.size()), 64'd0);

        // Streaming: 200 back-to-back beats into all three configurations
        p0 = pop0; p1 = pop1; p2 = pop2; c0s = acc0; c1s = acc1; c2s = acc2;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            a0 = 16'($urandom); b0 = 16'($urandom); cin0 = 1'($urandom); sub0 = 1'($urandom);
            a1 = $urandom; b1 = $urandom; cin1 = 1'($urandom); sub1 = 1'($urandom);
            if (i % 50 == 0) begin a0 = 16'hFFFF; a1 = 32'hFFFF_FFFF; end
            iv0 = 1'b1; iv1 = 1'b1;
        end
        @(posedge clk);
        #1;
        iv0 = 1'b0; iv1 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("stream_acc_w16", 64'(acc0 - c0s), 64'd200);
        chk("stream_acc_w4s1", 64'(acc1 - c1s), 64'd200);
        chk("stream_acc_w8s2", 64'(acc2 - c2s), 64'd200);
        chk("stream_pop_w16", 64'(pop0 - p0), 64'd200);
        chk("stream_pop_w4s1", 64'(pop1 - p1), 64'd200);
        chk("stream_pop_w8s2", 64'(pop2 - p2), 64'd200);

        // Reset with two beats in flight
        @(posedge clk);
        #1;
        a0 = 16'h0011; b0 = 16'h0022; cin0 = 1'b0; sub0 = 1'b0; iv0 = 1'b1;
        @(posedge clk);
        #1;
        a0 = 16'h0033; b0 = 16'h0044;
        @(posedge clk);
        #2;
        iv0 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid_async", {63'h0, ov0}, 64'd0);
        chk("rst_in_ready_low", {63'h0, ir0}, 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ir_after_release", {63'h0, ir0}, 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_stale", {63'h0, ov0}, 64'd0);
        end
        send0("post_rst", 16'h0100, 16'h0200, 1'b0, 1'b0, 16'h0300, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(q0.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
Name: cla_pipe_addsub

Overview:
Parametrised, pipelined two-level carry-lookahead adder/subtractor for the divider datapath. It generalises the fixed-width lookahead adder to any width that is a multiple of the group size. It adds a subtract mode and signed-overflow detection, and offers a selectable pipeline depth with valid/ready flow control. It is the remainder-update adder in the iterative divider and also serves as a general-purpose arithmetic unit.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of GROUP.
- GROUP, 4, bits per first-level lookahead group.
- STAGES, 2, pipeline depth; legal values are 1 and 2. Any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 selects A+B+cin; 1 selects A-B, computed as A+~B+1.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In subtract mode, cout=1 means no borrow.
- ovf  out  1  signed overflow, equal to carry into the MSB XOR carry out of the MSB.

Behaviour:
- Reset (async assert, sync release):
  - out_valid=0, sum=0, cout=0, ovf=0, all internal stage valids=0.
  - in_ready=0 while rst_n is low; in_ready=1 on the first clock after release.
- Effective operands:
  - b_eff = sub ? ~b : b.
  - c0 = sub ? 1 : cin.
- Bit level: g_i = a_i & b_eff_i; p_i = a_i | b_eff_i.
- Sum bit: s_i = a_i ^ b_eff_i ^ c_i.
- Group level: G = g_top | p_top&g_(top-1) | … ; P = AND of all p_i in the group.
- Second level: the carry into each group is computed by lookahead over the group G/P and c0. There is no ripple between groups.
- Within a group: carries are fully expanded lookahead terms from the group carry-in.
- STAGES=1:
  - One register at the output; in to out is combinational.
  - Latency is 1 cycle: a beat accepted at edge N gives out_valid=1 after edge N.
- STAGES=2:
  - Stage-1 register holds a, b_eff, group carry-ins and a valid bit.
  - Stage-2 (output) register holds sum, cout, ovf and out_valid.
  - Latency is 2 cycles.
- Handshake:
  - A transfer occurs when valid and ready are both 1 at a rising edge.
  - Each stage advances when it is empty or when the stage downstream of it advances. The output stage advances when out_valid=0 or out_ready=1.
  - in_ready = first stage empty OR first stage advancing. in_ready is combinational from out_ready.
  - Full throughput is 1 result per cycle with out_ready held at 1.
  - While out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
  - in_valid may drop without a transfer occurring.
  - Results are delivered in order. No beat is lost or duplicated.
- Simultaneous events: an output pop and an input accept in the same cycle are legal and keep the pipeline full.
- Reset mid-operation: all in-flight beats are discarded. out_valid falls immediately when rst_n asserts, without waiting for a clock. No stale result appears after release.
- Wrap-around: arithmetic is modulo 2^WIDTH; cout and ovf report the wrap.

Test Plan:
- (WIDTH=16, GROUP=4, STAGES=2) add 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, ovf=0. out_valid rises 2 cycles after accept.
- Add 0x7FFF+0x0001 → sum=0x8000, cout=0, ovf=1. Add 0x1234+0x0FFF, cin=1 → sum=0x2234, cout=0, ovf=0.
- Subtract:
  - 0x0005-0x0007 → sum=0xFFFE, cout=0, ovf=0.
  - 0x8000-0x0001 → sum=0x7FFF, cout=1, ovf=1.
  - For both, cin is driven to 1 and must be ignored.
- Backpressure: hold out_ready=0 and offer 4 beats. in_ready drops after exactly 2 accepts and the held sum stays stable. Then release out_ready; all 4 results emerge in order with no loss.
- Streaming: 200 back-to-back random beats with out_ready=1, repeated for STAGES=1 and STAGES=2, and for GROUP=4 and GROUP=8 at WIDTH=32. Expect one result per cycle matching the reference model.
- Reset mid-flight: assert rst_n low between clocks with 2 beats in flight. out_valid goes to 0 immediately. After release, in_ready=1 on the next edge and no result appears until a new beat is accepted.
